// File: rtl/noc_ni_pkg.sv
// Shared constants and types for the local-port network interface.
// Flit width, TX FSM states and default buffer sizing.
package noc_ni_pkg;

    localparam int DATA_W = 16;
    localparam int NI_BODY_FLITS = 3;
    localparam int NI_CREDITS = 8;
    localparam int NI_RX_DEPTH = 8;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_HEAD = 2'd1,
        TX_BODY = 2'd2
    } tx_state_t;

endpackage

// File: rtl/ni_rx_fifo.sv
// RX flit buffer with first-word fall-through head, sticky overflow
// flag and a registered credit pulse returned for every pop.
module ni_rx_fifo
    import noc_ni_pkg::*;
#(
    parameter int DEPTH = NI_RX_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              overflow_o,
    output logic              credit_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic              ovf_q, ovf_d;
    logic              credit_q;
    logic              empty, full, pop, push;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                   (wptr_q[AW] != rptr_q[AW]);
    assign pop   = !empty && rd_ready_i;
    assign push  = wr_valid_i && (!full || pop);

    assign rd_valid_o = !empty;
    assign rd_data_o  = mem_q[rptr_q[AW-1:0]];
    assign overflow_o = ovf_q;
    assign credit_o   = credit_q;

    // Pointer and overflow next-state
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        if (push)
            wptr_d = wptr_q + (AW+1)'(1);
        if (pop)
            rptr_d = rptr_q + (AW+1)'(1);
        if (wr_valid_i && full && !pop)
            ovf_d = 1'b1;
    end

    // Storage array; contents need no reset
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

    // Pointers, sticky overflow and credit-return pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            ovf_q    <= 1'b0;
            credit_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            ovf_q    <= ovf_d;
            credit_q <= pop;
        end
    end

endmodule

// File: rtl/local_network_interface.sv
// Local-port NI: packetizes core requests into header+body flits under
// credit flow control, and buffers router flits back to the core.
module local_network_interface
    import noc_ni_pkg::*;
#(
    parameter int BODY_FLITS = NI_BODY_FLITS,
    parameter int CREDITS    = NI_CREDITS,
    parameter int RX_DEPTH   = NI_RX_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tx_req_i,
    input  logic [15:0]                    tx_dest_i,
    output logic                           tx_idle_o,
    input  logic [DATA_W-1:0]              tx_data_i,
    input  logic                           tx_valid_i,
    output logic                           tx_ready_o,
    output logic [DATA_W-1:0]              noc_data_o,
    output logic                           noc_valid_o,
    input  logic                           noc_credit_i,
    input  logic [DATA_W-1:0]              noc_data_i,
    input  logic                           noc_valid_i,
    output logic                           noc_credit_o,
    output logic [DATA_W-1:0]              rx_data_o,
    output logic                           rx_valid_o,
    input  logic                           rx_ready_i,
    output logic                           rx_overflow_o,
    output logic [$clog2(CREDITS+1)-1:0]   tx_credits_o
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int NW = $clog2(BODY_FLITS + 1);

    tx_state_t         state_q, state_d;
    logic [15:0]       dest_q, dest_d;
    logic [NW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     cred_q, cred_d;
    logic [DATA_W-1:0] ndata_q;
    logic              nvalid_q;
    logic              can_send, emit;
    logic [DATA_W-1:0] flit;

    assign can_send     = (cred_q != '0);
    assign tx_idle_o    = (state_q == TX_IDLE);
    assign tx_ready_o   = (state_q == TX_BODY) && can_send;
    assign noc_data_o   = ndata_q;
    assign noc_valid_o  = nvalid_q;
    assign tx_credits_o = cred_q;

    // TX FSM: latch destination, emit header, then stream body flits
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
        flit    = tx_data_i;
        unique case (state_q)
            TX_IDLE: begin
                if (tx_req_i) begin
                    dest_d  = tx_dest_i;
                    state_d = TX_HEAD;
                end
            end
            TX_HEAD: begin
                if (can_send) begin
                    emit    = 1'b1;
                    flit    = DATA_W'(dest_q);
                    cnt_d   = '0;
                    state_d = TX_BODY;
                end
            end
            TX_BODY: begin
                if (tx_valid_i && can_send) begin
                    emit  = 1'b1;
                    cnt_d = cnt_q + NW'(1);
                    if (cnt_q == NW'(BODY_FLITS - 1))
                        state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Credits: spend one per flit, regain one per router pulse, saturate
    always_comb begin
        cred_d = cred_q;
        if (emit && !noc_credit_i)
            cred_d = cred_q - CW'(1);
        else if (noc_credit_i && !emit && cred_q < CW'(CREDITS))
            cred_d = cred_q + CW'(1);
    end

    // TX state, credit counter and registered flit output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= TX_IDLE;
            dest_q   <= '0;
            cnt_q    <= '0;
            cred_q   <= CW'(CREDITS);
            ndata_q  <= '0;
            nvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dest_q   <= dest_d;
            cnt_q    <= cnt_d;
            cred_q   <= cred_d;
            nvalid_q <= emit;
            if (emit)
                ndata_q <= flit;
        end
    end

    ni_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .wr_valid_i (noc_valid_i),
        .wr_data_i  (noc_data_i),
        .rd_ready_i (rx_ready_i),
        .rd_data_o  (rx_data_o),
        .rd_valid_o (rx_valid_o),
        .overflow_o (rx_overflow_o),
        .credit_o   (noc_credit_o)
    );

endmodule

// File: tb/tb_local_network_interface.sv
// Bench for local_network_interface: directed scenarios plus random
// traffic compared every cycle against a packet/queue-level model.
module tb_local_network_interface;

    localparam int BF = 3;
    localparam int NC = 8;
    localparam int RD = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tx_req = 1'b0;
    logic [15:0] tx_dest = '0;
    logic        tx_idle;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] noc_data_o;
    logic        noc_valid_o;
    logic        noc_credit_i = 1'b0;
    logic [15:0] noc_data_i = '0;
    logic        noc_valid_i = 1'b0;
    logic        noc_credit_o;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        rx_ovf;
    logic [3:0]  tx_credits;

    always #5 clk = ~clk;

    local_network_interface dut (
        .clk           (clk),
        .reset         (reset),
        .tx_req_i      (tx_req),
        .tx_dest_i     (tx_dest),
        .tx_idle_o     (tx_idle),
        .tx_data_i     (tx_data),
        .tx_valid_i    (tx_valid),
        .tx_ready_o    (tx_ready),
        .noc_data_o    (noc_data_o),
        .noc_valid_o   (noc_valid_o),
        .noc_credit_i  (noc_credit_i),
        .noc_data_i    (noc_data_i),
        .noc_valid_i   (noc_valid_i),
        .noc_credit_o  (noc_credit_o),
        .rx_data_o     (rx_data),
        .rx_valid_o    (rx_valid),
        .rx_ready_i    (rx_ready),
        .rx_overflow_o (rx_ovf),
        .tx_credits_o  (tx_credits)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // reference model state (packet position, credits, RX queue)
    bit          m_idle;
    int          m_pos;
    logic [15:0] m_dest;
    int          m_cred;
    bit          m_nv;
    logic [15:0] m_nd;
    bit          m_ncr;
    logic [15:0] m_rxq[$];
    bit          m_ovf;

    logic [15:0] txlog[$];
    int          txcyc[$];
    logic [15:0] poplog[$];
    int          ncr_cnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic bit m_rdy();
        return !m_idle && m_pos > 0 && m_cred > 0;
    endfunction

    task automatic model_reset();
        m_idle = 1; m_pos = 0; m_dest = '0; m_cred = NC;
        m_nv = 0; m_nd = '0; m_ncr = 0; m_rxq.delete(); m_ovf = 0;
    endtask

    task automatic model_adv();
        bit emit;
        bit pop;
        logic [15:0] f;
        emit = 0;
        f = '0;
        if (m_idle) begin
            if (tx_req) begin
                m_idle = 0; m_pos = 0; m_dest = tx_dest;
            end
        end else if (m_pos == 0) begin
            if (m_cred > 0) begin
                emit = 1; f = m_dest; m_pos = 1;
            end
        end else if (tx_valid && m_cred > 0) begin
            emit = 1; f = tx_data;
            if (m_pos == BF) m_idle = 1;
            else m_pos++;
        end
        if (emit && !noc_credit_i) m_cred--;
        else if (noc_credit_i && !emit && m_cred < NC) m_cred++;
        m_nv = emit;
        if (emit) m_nd = f;
        pop = (m_rxq.size() > 0) && rx_ready;
        m_ncr = pop;
        if (noc_valid_i) begin
            if (m_rxq.size() == RD && !pop) m_ovf = 1;
        end
        if (pop) void'(m_rxq.pop_front());
        if (noc_valid_i && !(m_rxq.size() == RD))
            m_rxq.push_back(noc_data_i);
    endtask

    task automatic compare();
        chk("tx_idle", tx_idle, m_idle);
        chk("tx_ready", tx_ready, m_rdy());
        chk("noc_valid", noc_valid_o, m_nv);
        chk("noc_data", noc_data_o, m_nd);
        chk("credits", tx_credits, m_cred);
        chk("noc_credit_o", noc_credit_o, m_ncr);
        chk("rx_valid", rx_valid, m_rxq.size() > 0);
        chk("rx_ovf", rx_ovf, m_ovf);
        if (m_rxq.size() > 0) chk("rx_data", rx_data, m_rxq[0]);
    endtask

    task automatic step();
        if (rx_ready && rx_valid) poplog.push_back(rx_data);
        model_adv();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare();
        if (noc_valid_o) begin
            txlog.push_back(noc_data_o);
            txcyc.push_back(cyc);
        end
        if (noc_credit_o) ncr_cnt++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 0;
        tx_req = 0; tx_valid = 0; noc_credit_i = 0;
        noc_valid_i = 0; rx_ready = 0;
        #1;
        chk("rst_noc_valid", noc_valid_o, 0);
        chk("rst_noc_data", noc_data_o, 0);
        chk("rst_noc_credit", noc_credit_o, 0);
        chk("rst_ovf", rx_ovf, 0);
        chk("rst_idle", tx_idle, 1);
        chk("rst_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_credits", tx_credits, NC);
        model_reset();
        @(negedge clk);
        reset = 1;
    endtask

    task automatic send_packet(input logic [15:0] d, input logic [15:0] b0,
                               input logic [15:0] b1, input logic [15:0] b2);
        logic [15:0] b[3];
        int idx;
        int guard;
        bit acc;
        b[0] = b0; b[1] = b1; b[2] = b2;
        tx_req = 1; tx_dest = d;
        step();
        tx_req = 0;
        idx = 0;
        guard = 0;
        while (idx < BF && guard < 100) begin
            tx_valid = 1; tx_data = b[idx];
            acc = m_rdy();
            step();
            if (acc) idx++;
            guard++;
        end
        tx_valid = 0;
        if (guard >= 100) chk("send_timeout", guard, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        ncr_cnt = 0;
        apply_reset();

        // 1: single packet, back-to-back flits
        txlog.delete(); txcyc.delete();
        send_packet(16'h0102, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        step();
        chk("t1_nflits", txlog.size(), 4);
        if (txlog.size() == 4) begin
            chk("t1_f0", txlog[0], 16'h0102);
            chk("t1_f1", txlog[1], 16'hAAAA);
            chk("t1_f2", txlog[2], 16'hBBBB);
            chk("t1_f3", txlog[3], 16'hCCCC);
            chk("t1_b2b", txcyc[3] - txcyc[0], 3);
        end
        chk("t1_credits", tx_credits, 4);
        chk("t1_idle", tx_idle, 1);

        // 2: credits exhausted, third packet stalls until one returns
        apply_reset();
        send_packet(16'h0101, 16'h1, 16'h2, 16'h3);
        send_packet(16'h0202, 16'h4, 16'h5, 16'h6);
        chk("t2_cred0", tx_credits, 0);
        tx_req = 1; tx_dest = 16'h0303;
        step();
        tx_req = 0;
        repeat (3) begin
            step();
            chk("t2_stall", noc_valid_o, 0);
        end
        chk("t2_busy", tx_idle, 0);
        noc_credit_i = 1;
        step();
        noc_credit_i = 0;
        chk("t2_no_same_cycle", noc_valid_o, 0);
        chk("t2_cred1", tx_credits, 1);
        step();
        chk("t2_head", noc_valid_o, 1);
        chk("t2_head_data", noc_data_o, 16'h0303);
        chk("t2_cred_back0", tx_credits, 0);

        // 3: concurrent credit and emission; saturation
        apply_reset();
        send_packet(16'h0011, 16'h1, 16'h2, 16'h3);
        noc_credit_i = 1;
        step();
        noc_credit_i = 0;
        chk("t3_cred5", tx_credits, 5);
        tx_req = 1; tx_dest = 16'h0022;
        step();
        tx_req = 0; noc_credit_i = 1;
        step();
        noc_credit_i = 0;
        chk("t3_emit", noc_valid_o, 1);
        chk("t3_hold5", tx_credits, 5);
        apply_reset();
        noc_credit_i = 1;
        step();
        noc_credit_i = 0;
        chk("t3_sat8", tx_credits, 8);

        // 4: RX fill, overflow, ordered drain with credit returns
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            noc_valid_i = 1; noc_data_i = 16'(i);
            step();
        end
        noc_valid_i = 0;
        chk("t4_valid", rx_valid, 1);
        chk("t4_head", rx_data, 16'h0001);
        chk("t4_no_ovf", rx_ovf, 0);
        noc_valid_i = 1; noc_data_i = 16'h0009;
        step();
        noc_valid_i = 0;
        chk("t4_ovf", rx_ovf, 1);
        poplog.delete(); ncr_cnt = 0;
        rx_ready = 1;
        repeat (8) step();
        rx_ready = 0;
        step();
        chk("t4_ncredits", ncr_cnt, 8);
        chk("t4_npop", poplog.size(), 8);
        foreach (poplog[i]) chk("t4_pop", poplog[i], 16'(i + 1));
        chk("t4_empty", rx_valid, 0);
        chk("t4_ovf_sticky", rx_ovf, 1);

        // 5: full FIFO, simultaneous write and pop
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            noc_valid_i = 1; noc_data_i = 16'(16'h10 + i);
            step();
        end
        noc_valid_i = 1; noc_data_i = 16'h0055; rx_ready = 1;
        step();
        noc_valid_i = 0; rx_ready = 0;
        chk("t5_no_ovf", rx_ovf, 0);
        chk("t5_head", rx_data, 16'h0012);
        poplog.delete();
        rx_ready = 1;
        repeat (8) step();
        rx_ready = 0;
        chk("t5_npop", poplog.size(), 8);
        if (poplog.size() == 8) chk("t5_tail", poplog[7], 16'h0055);

        // 6: reset mid-packet, then a clean packet
        apply_reset();
        noc_valid_i = 1; noc_data_i = 16'h0077;
        tx_req = 1; tx_dest = 16'h0A0B;
        step();
        noc_valid_i = 0; tx_req = 0;
        tx_valid = 1; tx_data = 16'h1111;
        step();
        tx_data = 16'h2222;
        step();
        tx_valid = 0;
        chk("t6_rx_before", rx_valid, 1);
        apply_reset();
        txlog.delete(); txcyc.delete();
        send_packet(16'h0C0D, 16'h3, 16'h4, 16'h5);
        step();
        chk("t6_nflits", txlog.size(), 4);
        if (txlog.size() == 4) chk("t6_head", txlog[0], 16'h0C0D);

        // random traffic against the model
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            tx_req       = ($urandom % 4) == 0;
            tx_dest      = 16'($urandom);
            tx_valid     = ($urandom % 3) != 0;
            tx_data      = 16'($urandom);
            noc_credit_i = ($urandom % 3) == 0;
            noc_valid_i  = ($urandom % 2) == 0;
            noc_data_i   = 16'($urandom);
            rx_ready     = ($urandom % 3) != 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/local_network_interface.md
Name: local_network_interface

Overview:
Local-port network interface between a processing core and the local (L) port of a mesh router (edge or interior).
- TX path: packetizes core requests into a header flit plus BODY_FLITS body flits, and drives the router's l_data_i/l_valid_i.
- TX flow control: sending is gated by a credit counter that the router replenishes via its l_credit_o pulses.
- RX path: buffers flits arriving from the router's l_data_o/l_valid_o, presents them to the core, and returns one credit pulse to the router's l_credit_i per flit consumed.

Parameters:
DATA_W, 16, flit width; the header flit is the 16-bit yx destination address.
BODY_FLITS, 3, body flits per packet (≥1); a packet is 1+BODY_FLITS flits.
CREDITS, 8, initial/max TX credits; equals router input-buffer depth.
RX_DEPTH, 8, RX FIFO entries (power of 2, ≥ router downstream credit count).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (reset==0 resets)
tx_req_i  in  1  start-of-packet request
tx_dest_i  in  16  yx destination, sampled with tx_req_i
tx_idle_o  out  1  TX FSM in IDLE; request accepted when tx_req_i & tx_idle_o
tx_data_i  in  DATA_W  body flit from core
tx_valid_i  in  1  body flit valid
tx_ready_o  out  1  body flit accepted this cycle when tx_valid_i & tx_ready_o
noc_data_o  out  DATA_W  flit to router L input
noc_valid_o  out  1  flit valid to router (write strobe)
noc_credit_i  in  1  credit pulse from router (one per freed slot)
noc_data_i  in  DATA_W  flit from router L output
noc_valid_i  in  1  flit valid from router
noc_credit_o  out  1  credit pulse to router
rx_data_o  out  DATA_W  RX FIFO head (first-word fall-through)
rx_valid_o  out  1  RX FIFO non-empty
rx_ready_i  in  1  core pops head when rx_valid_o & rx_ready_i
rx_overflow_o  out  1  sticky: flit arrived while FIFO full
tx_credits_o  out  $clog2(CREDITS+1)  current credit count

Behaviour:
Reset (reset==0, asynchronous):
- FSM=IDLE; credits=CREDITS; RX FIFO empty.
- Outputs: noc_valid_o=0, noc_data_o=0, noc_credit_o=0, rx_overflow_o=0, tx_idle_o=1, tx_ready_o=0, rx_valid_o=0.
- Reset mid-packet abandons the packet; no partial-flush flits are emitted.

TX FSM has three states: IDLE, HEAD, BODY.
- IDLE: on tx_req_i, latch tx_dest_i and go to HEAD.
- HEAD: if credits>0, emit the header (dest) and go to BODY with cnt=0; else stall in HEAD.
- BODY: tx_ready_o = (credits>0), combinational. On tx_valid_i & tx_ready_o, emit tx_data_i and increment cnt; when cnt==BODY_FLITS-1 at that fire, go to IDLE. Otherwise hold.

TX outputs:
- noc_data_o/noc_valid_o are registered: a flit fired at edge N appears after edge N with valid high for exactly one cycle.
- noc_data_o holds its last value when noc_valid_o=0.
- Back-to-back flits are allowed. Minimum packet time is 1+BODY_FLITS cycles after HEAD entry.

Credit counter:
- Decrement on each emitted flit; increment on noc_credit_i.
- Both in the same cycle: no change.
- Increment at CREDITS saturates (pulse ignored).
- Never below 0; emission is blocked at 0.
- A credit arriving in a cycle where credits==0 enables emission on the next cycle, not the same cycle.

RX path:
- Write on noc_valid_i, 1-cycle write-to-rx_valid_o latency.
- Pop on rx_valid_o & rx_ready_i. noc_credit_o is a registered one-cycle pulse the cycle after each pop.
- Full with write and pop in the same cycle: both occur, no overflow.
- Full with write and no pop: flit dropped, rx_overflow_o set until reset.
- Empty with write: no same-cycle bypass.
- Pointers wrap modulo RX_DEPTH; there is one extra bit each for full/empty detection.

Decomposition:
- Package noc_ni_pkg holds DATA_W, the tx_state_t enum (IDLE/HEAD/BODY), and default CREDITS/RX_DEPTH constants.
- Sub-module ni_rx_fifo contains the RX FIFO, overflow flag, and credit-return register.
- The TX FSM and credit counter stay in the top module.

Test Plan:
1. Reset release; tx_req_i with dest 16'h0102 and body flits AAAA/BBBB/CCCC back-to-back, no returns → noc_valid_o high 4 consecutive cycles with 0102, AAAA, BBBB, CCCC; tx_credits_o=4; tx_idle_o=1 after.
2. Two packets, no noc_credit_i → 8 flits sent, then the 3rd packet stalls in HEAD with noc_valid_o=0. A single noc_credit_i pulse → header emitted the next cycle; credits return to 0.
3. noc_credit_i concurrent with a flit emission at credits=5 → credits stay 5. noc_credit_i with credits=8 → stays 8.
4. RX: write 8 flits (0x0001..0x0008) with rx_ready_i=0 → rx_valid_o=1, head=0001, no overflow. A 9th write with no pop → rx_overflow_o=1 and 0x0009 lost. Then pop all → data 0001..0008 in order, 8 noc_credit_o pulses each one cycle after its pop.
5. Full FIFO, simultaneous noc_valid_i and pop → no overflow; the FIFO stays full with the new flit at the tail.
6. Assert reset after the header plus 1 body flit → immediately noc_valid_o=0, tx_idle_o=1, credits=8, rx_valid_o=0. A new packet after release is emitted cleanly.
